// File: rtl/button_parse_pkg.sv
// Shared definitions for the button event parser: long-press FSM encoding,
// default 125 MHz timing constants and a counter-width helper.
package button_parse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } lp_state_e;

    localparam int unsigned DEF_WIDTH          = 1;
    localparam int unsigned DEF_SAMPLE_CNT_MAX = 62500;  // 500 us at 125 MHz
    localparam int unsigned DEF_PULSE_CNT_MAX  = 200;
    localparam int unsigned DEF_LONG_CNT_MAX   = 2000;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: saturating debounce counter on the shared sample tick,
// edge detect on the debounced level, and the one-shot long-press FSM.
module debounce_channel
    import button_parse_pkg::*;
#(
    parameter int unsigned PULSE_CNT_MAX = DEF_PULSE_CNT_MAX,
    parameter int unsigned LONG_CNT_MAX  = DEF_LONG_CNT_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic sync_i,
    output logic debounced_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int unsigned CW = cnt_w(PULSE_CNT_MAX + 1);
    localparam int unsigned HW = cnt_w(LONG_CNT_MAX);
    localparam logic [CW-1:0] CNT_TOP  = CW'(PULSE_CNT_MAX);
    localparam logic [HW-1:0] HOLD_TOP = HW'(LONG_CNT_MAX - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q;
    logic          deb_next;
    lp_state_e     state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Debounce counter: count high ticks up to the threshold, any low tick clears.
    always_comb begin
        cnt_d = cnt_q;
        if (tick_i) begin
            if (!sync_i)
                cnt_d = '0;
            else if (cnt_q != CNT_TOP)
                cnt_d = cnt_q + 1'b1;
        end
    end

    // Level decoded straight from the register, so it cannot glitch.
    assign debounced_o = (cnt_q == CNT_TOP);
    assign deb_next    = (cnt_d == CNT_TOP);
    assign press_o     = debounced_o & ~deb_q;
    assign release_o   = ~debounced_o & deb_q;
    assign long_o      = long_q;

    // Long-press next state; a release landing on the threshold tick suppresses the pulse.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        long_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_o) begin
                    state_d = HELD;
                    hold_d  = '0;
                end
            end
            HELD: begin
                if (release_o) begin
                    state_d = IDLE;
                end else if (tick_i) begin
                    if (hold_q == HOLD_TOP) begin
                        if (deb_next) begin
                            state_d = LONG;
                            long_d  = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            LONG: begin
                if (release_o)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Channel state registers; reset clears everything so no pulse follows reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            deb_q   <= 1'b0;
            state_q <= IDLE;
            hold_q  <= '0;
            long_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            deb_q   <= debounced_o;
            state_q <= state_d;
            hold_q  <= hold_d;
            long_q  <= long_d;
        end
    end

endmodule

// File: rtl/button_event_parser.sv
// Button event parser top: owns the shared sample-tick counter and one
// debounce_channel per synchronized button bit.
module button_event_parser
    import button_parse_pkg::*;
#(
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned SAMPLE_CNT_MAX = DEF_SAMPLE_CNT_MAX,
    parameter int unsigned PULSE_CNT_MAX  = DEF_PULSE_CNT_MAX,
    parameter int unsigned LONG_CNT_MAX   = DEF_LONG_CNT_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sync_signal,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_pulse
);

    localparam int unsigned SW = cnt_w(SAMPLE_CNT_MAX);
    localparam logic [SW-1:0] SMP_TOP = SW'(SAMPLE_CNT_MAX - 1);

    logic [SW-1:0] smp_q, smp_d;
    logic          tick;

    assign tick  = (smp_q == SMP_TOP);
    assign smp_d = tick ? '0 : smp_q + 1'b1;

    // Free-running sample counter; tick marks its last count before wrap.
    always_ff @(posedge clk) begin
        if (!rst_n)
            smp_q <= '0;
        else
            smp_q <= smp_d;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .PULSE_CNT_MAX (PULSE_CNT_MAX),
            .LONG_CNT_MAX  (LONG_CNT_MAX)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick_i      (tick),
            .sync_i      (sync_signal[i]),
            .debounced_o (debounced[i]),
            .press_o     (press_pulse[i]),
            .release_o   (release_pulse[i]),
            .long_o      (long_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_event_parser.sv
// Directed bench for button_event_parser with short timing constants:
// tick every 4 cycles, press after 3 high ticks, long press after 5 more ticks.
module tb_button_event_parser;

    localparam int W    = 2;
    localparam int SMAX = 4;
    localparam int PMAX = 3;
    localparam int LMAX = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sync_signal = '0;
    logic [W-1:0] debounced, press_pulse, release_pulse, long_pulse;

    button_event_parser #(
        .WIDTH          (W),
        .SAMPLE_CNT_MAX (SMAX),
        .PULSE_CNT_MAX  (PMAX),
        .LONG_CNT_MAX   (LMAX)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sync_signal   (sync_signal),
        .debounced     (debounced),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge N settles, cyc == N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event counters and last-event cycle per channel, sampled mid-cycle.
    int np[W], nr[W], nl[W], nd[W], tp[W], tr[W], tl[W];
    always @(negedge clk) begin
        for (int b = 0; b < W; b++) begin
            if (press_pulse[b])   begin np[b] = np[b] + 1; tp[b] = cyc; end
            if (release_pulse[b]) begin nr[b] = nr[b] + 1; tr[b] = cyc; end
            if (long_pulse[b])    begin nl[b] = nl[b] + 1; tl[b] = cyc; end
            if (debounced[b])     nd[b] = nd[b] + 1;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int rst_cyc = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Park just after a tick edge so later ticks land at A+4, A+8, ...
    task automatic align();
        while (((cyc - rst_cyc) % SMAX) != 0) step(1);
    endtask

    int a, f;
    int b_np0, b_nr0, b_nl0, b_nd0, b_np1, b_nr1, b_nl1;

    task automatic snap();
        b_np0 = np[0]; b_nr0 = nr[0]; b_nl0 = nl[0]; b_nd0 = nd[0];
        b_np1 = np[1]; b_nr1 = nr[1]; b_nl1 = nl[1];
    endtask

    initial begin
        // Reset held 3 edges with both inputs high: outputs stay low.
        rst_n = 1'b0;
        sync_signal = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("rst_outputs_low", {debounced, press_pulse, release_pulse, long_pulse}, 0);
        end
        rst_cyc = cyc;
        rst_n = 1'b1;
        step(11);
        check("deb_before_edge12", debounced, 0);
        check("press_before_edge12", press_pulse, 0);
        step(1);
        check("deb_at_edge12", debounced, 2'b11);
        check("press_at_edge12", press_pulse, 2'b11);
        step(1);
        check("press_one_cycle", press_pulse, 0);
        check("deb_held", debounced, 2'b11);
        sync_signal = 2'b00;
        step(20);
        check("rst_seq_release0", nr[0], 1);
        check("rst_seq_release1", nr[1], 1);
        check("rst_seq_no_long", nl[0] + nl[1], 0);

        // Glitch: 7 high cycles see at most 2 ticks.
        snap();
        sync_signal[0] = 1'b1;
        step(7);
        sync_signal[0] = 1'b0;
        step(20);
        check("glitch_no_deb", nd[0] - b_nd0, 0);
        check("glitch_no_press", np[0] - b_np0, 0);
        check("glitch_no_release", nr[0] - b_nr0, 0);
        check("glitch_no_long", nl[0] - b_nl0, 0);

        // Clean press, held 24 cycles: too short for the long threshold.
        align();
        snap();
        a = cyc;
        sync_signal[0] = 1'b1;
        step(24);
        sync_signal[0] = 1'b0;
        f = cyc;
        step(12);
        check("clean_press_cnt", np[0] - b_np0, 1);
        check("clean_release_cnt", nr[0] - b_nr0, 1);
        check("clean_no_long", nl[0] - b_nl0, 0);
        check("clean_press_time", tp[0] - a, 12);
        check("clean_fall_latency_le4", ((tr[0] - f) >= 1 && (tr[0] - f) <= 4) ? 1 : 0, 1);

        // Release on the same tick as the long threshold: release wins.
        align();
        snap();
        a = cyc;
        sync_signal[0] = 1'b1;
        step(28);
        sync_signal[0] = 1'b0;
        step(12);
        check("tie_release_time", tr[0] - a, 32);
        check("tie_no_long", nl[0] - b_nl0, 0);
        check("tie_release_cnt", nr[0] - b_nr0, 1);

        // Long hold: long pulse once, 20 cycles after press.
        align();
        snap();
        a = cyc;
        sync_signal[0] = 1'b1;
        step(80);
        sync_signal[0] = 1'b0;
        step(12);
        check("long_cnt_once", nl[0] - b_nl0, 1);
        check("long_press_time", tp[0] - a, 12);
        check("long_after_press", tl[0] - tp[0], 20);
        check("long_press_cnt", np[0] - b_np0, 1);
        check("long_release_cnt", nr[0] - b_nr0, 1);
        check("long_release_time", tr[0] - a, 84);

        // Independence: bit1 clean press while bit0 glitches 2 of every 6 cycles.
        align();
        snap();
        a = cyc;
        for (int j = 0; j < 36; j++) begin
            sync_signal[1] = (j < 24);
            sync_signal[0] = ((j % 6) < 2);
            step(1);
        end
        sync_signal = 2'b00;
        step(12);
        check("indep_b1_press_time", tp[1] - a, 12);
        check("indep_b1_release_time", tr[1] - a, 28);
        check("indep_b1_press_cnt", np[1] - b_np1, 1);
        check("indep_b1_no_long", nl[1] - b_nl1, 0);
        check("indep_b0_no_deb", nd[0] - b_nd0, 0);
        check("indep_b0_no_events", (np[0] - b_np0) + (nr[0] - b_nr0) + (nl[0] - b_nl0), 0);

        // Reset mid-press: level drops, no release, full re-qualification.
        align();
        snap();
        a = cyc;
        sync_signal[0] = 1'b1;
        step(14);
        check("midrst_deb_before", debounced[0], 1);
        rst_n = 1'b0;
        step(1);
        check("midrst_deb_low", debounced[0], 0);
        check("midrst_no_release_pulse", release_pulse[0], 0);
        rst_cyc = cyc;
        rst_n = 1'b1;
        step(11);
        check("midrst_deb_before_requal", debounced[0], 0);
        step(1);
        check("midrst_requal_press", press_pulse[0], 1);
        sync_signal[0] = 1'b0;
        step(12);
        check("midrst_release_cnt", nr[0] - b_nr0, 1);
        check("midrst_press_cnt", np[0] - b_np0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard bound on run length.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
